// File: rtl/brightness_row_sequencer_if.sv
`timescale 1ns/1ps
// Display-side bundle between the row sequencer, the column shifter and brightness_timeout.
// The master modport belongs to the sequencer; the slave modport is the shifter/timeout side.
interface brightness_row_sequencer_if #(
  parameter int BRIGHTNESS_LEVELS = 8,
  parameter int ROWS              = 16
);
  localparam int RW = $clog2(ROWS);

  logic                         enable;
  logic                         shift_done;
  logic                         exceeded_overlap_time;
  logic                         shift_start;
  logic [BRIGHTNESS_LEVELS-1:0] load_mask;
  logic [RW-1:0]                load_row;
  logic                         row_latch;
  logic [BRIGHTNESS_LEVELS-1:0] brightness_mask_active;
  logic [RW-1:0]                row_address;
  logic                         frame_start;
  logic                         stall;

  modport master (
    input  enable, shift_done, exceeded_overlap_time,
    output shift_start, load_mask, load_row, row_latch,
           brightness_mask_active, row_address, frame_start, stall
  );

  modport slave (
    output enable, shift_done, exceeded_overlap_time,
    input  shift_start, load_mask, load_row, row_latch,
           brightness_mask_active, row_address, frame_start, stall
  );
endinterface

// File: rtl/brightness_row_sequencer.sv
`timescale 1ns/1ps
// Steps bit planes MSB->LSB per row, rows ascending with wrap; requests a column shift, then latches
// once the previous plane's window has expired. shift_start 1 cycle after IDLE exit, row_latch 1 cycle after DRAIN exit.
module brightness_row_sequencer #(
  parameter int BRIGHTNESS_LEVELS = 8,
  parameter int ROWS              = 16,
  parameter int MAX_WAIT          = 4096
) (
  input  logic                        clk_in,
  input  logic                        reset_n,
  brightness_row_sequencer_if.master  bus
);
  localparam int RW = $clog2(ROWS);
  localparam int WW = $clog2(MAX_WAIT);
  localparam logic [BRIGHTNESS_LEVELS-1:0] MASK_MSB = {1'b1, {(BRIGHTNESS_LEVELS-1){1'b0}}};
  localparam logic [BRIGHTNESS_LEVELS-1:0] MASK_LSB = {{(BRIGHTNESS_LEVELS-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0]                ROW_LAST  = RW'(ROWS - 1);
  localparam logic [WW-1:0]                WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_REQ,
    S_SHIFT_WAIT,
    S_DRAIN,
    S_LATCH
  } state_t;

  state_t                       state_q, state_d;
  logic [BRIGHTNESS_LEVELS-1:0] load_mask_q, load_mask_d;
  logic [RW-1:0]                load_row_q, load_row_d;
  logic [BRIGHTNESS_LEVELS-1:0] mask_active_q, mask_active_d;
  logic [RW-1:0]                row_address_q, row_address_d;
  logic                         shift_start_q, shift_start_d;
  logic                         row_latch_q, row_latch_d;
  logic                         frame_start_q, frame_start_d;
  logic                         stall_q, stall_d;
  logic                         first_plane_q, first_plane_d;
  logic [WW-1:0]                wait_cnt_q, wait_cnt_d;
  logic                         go_latch;

  always_comb begin
    state_d       = state_q;
    load_mask_d   = load_mask_q;
    load_row_d    = load_row_q;
    mask_active_d = mask_active_q;
    row_address_d = row_address_q;
    shift_start_d = 1'b0;
    row_latch_d   = 1'b0;
    frame_start_d = 1'b0;
    stall_d       = stall_q;
    first_plane_d = first_plane_q;
    wait_cnt_d    = wait_cnt_q;
    go_latch      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          state_d       = S_SHIFT_REQ;
          shift_start_d = 1'b1;
        end
      end
      S_SHIFT_REQ: begin
        state_d = S_SHIFT_WAIT;
      end
      S_SHIFT_WAIT: begin
        if (bus.shift_done) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Nothing is on display before the first latch, so there is no window to wait out.
        if (first_plane_q || bus.exceeded_overlap_time) begin
          go_latch = 1'b1;
        end else if (wait_cnt_q == WAIT_LAST) begin
          go_latch = 1'b1;
          stall_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (go_latch) begin
          state_d       = S_LATCH;
          wait_cnt_d    = '0;
          row_latch_d   = 1'b1;
          mask_active_d = load_mask_q;
          row_address_d = load_row_q;
          frame_start_d = !first_plane_q && (load_mask_q == MASK_MSB) && (load_row_q == '0);
          first_plane_d = 1'b0;
        end
      end
      S_LATCH: begin
        if (load_mask_q == MASK_LSB) begin
          load_mask_d = MASK_MSB;
          load_row_d  = (load_row_q == ROW_LAST) ? '0 : load_row_q + 1'b1;
        end else begin
          load_mask_d = load_mask_q >> 1;
        end
        if (bus.enable) begin
          state_d       = S_SHIFT_REQ;
          shift_start_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      load_mask_q   <= MASK_MSB;
      load_row_q    <= '0;
      mask_active_q <= MASK_MSB;
      row_address_q <= '0;
      shift_start_q <= 1'b0;
      row_latch_q   <= 1'b0;
      frame_start_q <= 1'b0;
      stall_q       <= 1'b0;
      first_plane_q <= 1'b1;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      load_mask_q   <= load_mask_d;
      load_row_q    <= load_row_d;
      mask_active_q <= mask_active_d;
      row_address_q <= row_address_d;
      shift_start_q <= shift_start_d;
      row_latch_q   <= row_latch_d;
      frame_start_q <= frame_start_d;
      stall_q       <= stall_d;
      first_plane_q <= first_plane_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign bus.shift_start            = shift_start_q;
  assign bus.load_mask              = load_mask_q;
  assign bus.load_row               = load_row_q;
  assign bus.row_latch              = row_latch_q;
  assign bus.brightness_mask_active = mask_active_q;
  assign bus.row_address            = row_address_q;
  assign bus.frame_start            = frame_start_q;
  assign bus.stall                  = stall_q;

endmodule

// File: tb/tb_brightness_row_sequencer.sv
`timescale 1ns/1ps
// Bench for brightness_row_sequencer: cycle table, hand-built corner sequences, and a randomized run
// checked against a plane-index model (n-th latch shows row (n/BL)%ROWS, plane BL-1-(n%BL)).
module tb_brightness_row_sequencer;
  localparam int BL = 4;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  brightness_row_sequencer_if #(.BRIGHTNESS_LEVELS(BL), .ROWS(NR)) ifa ();
  brightness_row_sequencer_if #(.BRIGHTNESS_LEVELS(BL), .ROWS(NR)) ifb ();

  brightness_row_sequencer #(.BRIGHTNESS_LEVELS(BL), .ROWS(NR), .MAX_WAIT(64)) dut_a (
    .clk_in(clk), .reset_n(rst_a_n), .bus(ifa)
  );
  brightness_row_sequencer #(.BRIGHTNESS_LEVELS(BL), .ROWS(NR), .MAX_WAIT(8)) dut_b (
    .clk_in(clk), .reset_n(rst_b_n), .bus(ifb)
  );

  typedef struct {
    logic       en, sd, ex;
    logic       ss, rl, fs;
    logic [3:0] ma;
    logic       ra;
  } vec_t;

  vec_t tbl[31];

  function automatic vec_t mk(input int en, sd, ex, ss, rl, fs, ma, ra);
    vec_t v;
    v.en = 1'(en); v.sd = 1'(sd); v.ex = 1'(ex);
    v.ss = 1'(ss); v.rl = 1'(rl); v.fs = 1'(fs);
    v.ma = 4'(ma); v.ra = 1'(ra);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {shift_start, row_latch, frame_start, stall, mask_active, row_address}
  function automatic logic [31:0] outs_a();
    return 32'({ifa.shift_start, ifa.row_latch, ifa.frame_start, ifa.stall,
                ifa.brightness_mask_active, ifa.row_address});
  endfunction

  function automatic logic [31:0] pack_exp(input logic ss, rl, fs, st, input logic [3:0] ma,
                                           input logic ra);
    return 32'({ss, rl, fs, st, ma, ra});
  endfunction

  task automatic cyc_a(input logic en, sd, ex);
    @(negedge clk);
    ifa.enable = en; ifa.shift_done = sd; ifa.exceeded_overlap_time = ex;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input logic en, sd, ex);
    @(negedge clk);
    ifb.enable = en; ifb.shift_done = sd; ifb.exceeded_overlap_time = ex;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a_n = 1'b0;
    ifa.enable = 1'b0; ifa.shift_done = 1'b0; ifa.exceeded_overlap_time = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_a_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_m [10];
    int         exp_r [10];
    int         n_lat, n_ss, c0, ss_cyc2, rl_cyc2, st_at1, st_at2, st_before2, st_low_seen;
    logic       bad_ss, bad_rl, prev_rl, prev_st, en, sd, ex, inv;
    logic [31:0] exp_lm;

    ifb.enable = 1'b0; ifb.shift_done = 1'b0; ifb.exceeded_overlap_time = 1'b0;

    tbl[0] = mk(1, 0, 0, 1, 0, 0, 8, 0);
    tbl[1] = mk(1, 0, 0, 0, 0, 0, 8, 0);
    tbl[2] = mk(1, 0, 0, 0, 0, 0, 8, 0);
    tbl[3] = mk(1, 1, 0, 0, 0, 0, 8, 0);
    tbl[4] = mk(1, 0, 0, 0, 1, 0, 8, 0);
    tbl[5] = mk(1, 0, 0, 1, 0, 0, 8, 0);
    tbl[6] = mk(1, 0, 0, 0, 0, 0, 8, 0);
    tbl[7] = mk(1, 1, 0, 0, 0, 0, 8, 0);
    for (int i = 8; i < 28; i++) tbl[i] = mk(1, 0, 0, 0, 0, 0, 8, 0);
    tbl[28] = mk(1, 0, 1, 0, 1, 0, 4, 0);
    tbl[29] = mk(0, 0, 0, 0, 0, 0, 4, 0);
    tbl[30] = mk(0, 0, 0, 0, 0, 0, 4, 0);

    exp_m = '{4'd8, 4'd4, 4'd2, 4'd1, 4'd8, 4'd4, 4'd2, 4'd1, 4'd8, 4'd4};
    exp_r = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

    // Reset values
    reset_a();
    chk("reset_outputs", outs_a(), pack_exp(0, 0, 0, 0, 4'd8, 1'b0));
    chk("reset_load_mask", 32'(ifa.load_mask), 32'd8);
    chk("reset_load_row", 32'(ifa.load_row), 32'd0);

    // First-plane bypass, 20-cycle DRAIN hold, enable low at LATCH
    for (int i = 0; i < 31; i++) begin
      cyc_a(tbl[i].en, tbl[i].sd, tbl[i].ex);
      chk($sformatf("table_%0d", i), outs_a(),
          pack_exp(tbl[i].ss, tbl[i].rl, tbl[i].fs, 1'b0, tbl[i].ma, tbl[i].ra));
    end
    chk("idle_load_mask", 32'(ifa.load_mask), 32'd2);

    // enable dropped during SHIFT_WAIT, then resume at the following plane
    cyc_a(1, 0, 0);
    chk("resume_ss", 32'(ifa.shift_start), 32'd1);
    chk("resume_load_mask", 32'(ifa.load_mask), 32'd2);
    cyc_a(0, 0, 0);
    cyc_a(0, 1, 0);
    cyc_a(0, 0, 1);
    chk("drop_latch", outs_a(), pack_exp(0, 1, 0, 0, 4'd2, 1'b0));
    bad_ss = 1'b0; bad_rl = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc_a(0, 1, 1);
      bad_ss |= ifa.shift_start;
      bad_rl |= ifa.row_latch;
    end
    chk("idle_no_shift", 32'(bad_ss), 32'd0);
    chk("idle_no_latch", 32'(bad_rl), 32'd0);
    cyc_a(1, 0, 0);
    chk("reenable_ss", 32'(ifa.shift_start), 32'd1);
    chk("reenable_load_mask", 32'(ifa.load_mask), 32'd1);
    chk("reenable_load_row", 32'(ifa.load_row), 32'd0);
    cyc_a(1, 0, 0);
    cyc_a(1, 1, 1);
    chk("both_high_no_latch", 32'(ifa.row_latch), 32'd0);
    cyc_a(1, 0, 1);
    chk("both_high_latch_next", outs_a(), pack_exp(0, 1, 0, 0, 4'd1, 1'b0));

    // Auto-ack from reset: full frame then wrap, then reset during LATCH
    reset_a();
    n_lat = 0;
    for (int c = 0; c < 200 && n_lat < 10; c++) begin
      cyc_a(1, 1, 1);
      if (ifa.row_latch) begin
        if (n_lat < 9) begin
          chk($sformatf("auto_latch_%0d", n_lat),
              32'({ifa.frame_start, ifa.brightness_mask_active, ifa.row_address}),
              32'({(n_lat == 8), exp_m[n_lat], 1'(exp_r[n_lat])}));
        end else begin
          chk("pre_reset_mask", 32'(ifa.brightness_mask_active), 32'(exp_m[9]));
          rst_a_n = 1'b0;
          #1;
          chk("async_reset_outputs", outs_a(), pack_exp(0, 0, 0, 0, 4'd8, 1'b0));
          chk("async_reset_load", 32'({ifa.load_mask, ifa.load_row}), 32'({4'd8, 1'b0}));
        end
        n_lat++;
      end
    end
    chk("auto_latch_count", 32'(n_lat), 32'd10);

    // Randomized run against the plane-index model
    reset_a();
    n_lat = 0; n_ss = 0;
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 9) < 8);
      sd = ($urandom_range(0, 9) < 3);
      ex = ($urandom_range(0, 9) < 4);
      prev_rl = ifa.row_latch;
      cyc_a(en, sd, ex);
      if (prev_rl) chk("rand_after_latch_ss", 32'(ifa.shift_start), 32'(en));
      if (ifa.shift_start) begin
        exp_lm = 32'd1 << (BL - 1 - (n_ss % BL));
        chk("rand_ss_enable", 32'(en), 32'd1);
        chk("rand_ss_mask", 32'(ifa.load_mask), exp_lm);
        chk("rand_ss_row", 32'(ifa.load_row), 32'((n_ss / BL) % NR));
        chk("rand_ss_order", 32'(n_lat), 32'(n_ss));
        n_ss++;
      end
      if (ifa.row_latch) begin
        exp_lm = 32'd1 << (BL - 1 - (n_lat % BL));
        chk("rand_latch_mask", 32'(ifa.brightness_mask_active), exp_lm);
        chk("rand_latch_row", 32'(ifa.row_address), 32'((n_lat / BL) % NR));
        chk("rand_latch_frame", 32'(ifa.frame_start),
            32'((n_lat > 0) && (n_lat % (BL * NR) == 0)));
        chk("rand_latch_order", 32'(n_lat + 1), 32'(n_ss));
        chk("rand_latch_cause", 32'((n_lat == 0) || ex), 32'd1);
        n_lat++;
      end else begin
        chk("rand_frame_without_latch", 32'(ifa.frame_start), 32'd0);
      end
      inv = $onehot(ifa.brightness_mask_active) && $onehot(ifa.load_mask) &&
            !(ifa.shift_start && ifa.row_latch) && !ifa.stall;
      chk("rand_invariants", 32'(inv), 32'd1);
    end
    chk("rand_progress", 32'(n_lat > 100), 32'd1);

    // DRAIN watchdog on the MAX_WAIT=8 instance
    @(negedge clk);
    rst_b_n = 1'b1;
    n_lat = 0; n_ss = 0; ss_cyc2 = -1; rl_cyc2 = -1;
    st_at1 = -1; st_at2 = -1; st_before2 = -1; prev_st = 1'b0;
    for (int c = 0; c < 100 && n_lat < 2; c++) begin
      prev_st = ifb.stall;
      cyc_b(1, 1, 0);
      if (ifb.shift_start) begin
        n_ss++;
        if (n_ss == 2) ss_cyc2 = c;
      end
      if (ifb.row_latch) begin
        n_lat++;
        if (n_lat == 1) st_at1 = int'(ifb.stall);
        if (n_lat == 2) begin
          rl_cyc2 = c; st_at2 = int'(ifb.stall); st_before2 = int'(prev_st);
        end
      end
    end
    chk("wdog_first_latch_stall", 32'(st_at1), 32'd0);
    chk("wdog_stall_before", 32'(st_before2), 32'd0);
    chk("wdog_stall_at_latch", 32'(st_at2), 32'd1);
    chk("wdog_ss_to_latch", 32'(rl_cyc2 - ss_cyc2), 32'd10);
    st_low_seen = 0;
    for (int c = 0; c < 30; c++) begin
      cyc_b(1, 1, 1);
      if (!ifb.stall) st_low_seen++;
    end
    chk("wdog_stall_sticky", 32'(st_low_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
